ofmap_writer: RTL and testbench

Downstream stage of the accelerator system. Consumes the output stream (data word plus x/y/channel coordinates) and writes each word into a dedicated result memory at a linear channel-major address through a small elastic buffer. Counts received words against a programmed total and reports completion, so the testbench or host knows when the full output feature map has reached memory.

---
 rtl/ofmap_writer_pkg.sv | 26 ++
 rtl/ofmap_writer_fifo.sv | 62 ++++++
 rtl/ofmap_writer.sv | 183 ++++++++++++++++++
 tb/tb_ofmap_writer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofmap_writer_pkg.sv
// Shared types and width helpers for the output feature-map writer.
// Widths derive from the feature-map and memory geometry parameters.
package ofmap_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Index width for a range, never narrower than one bit
  function automatic int coord_width(input int range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

  function automatic int addr_width(input int depth);
    return coord_width(depth);
  endfunction

  // One extra bit so a full frame count is representable
  function automatic int count_width(input int xw, input int yw, input int cw);
    return xw + yw + cw + 1;
  endfunction

endpackage

// File: rtl/ofmap_writer_fifo.sv
// Small synchronous FIFO holding {address, data} write requests.
// A push on full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTRW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTRW-1:0]  wr_ptr_r;
  logic [PTRW-1:0]  rd_ptr_r;
  logic [PTRW:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == (PTRW+1)'(DEPTH));
  assign empty     = (count_r == {(PTRW+1){1'b0}});
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  // Storage array; data is only observed through valid head entries
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTRW{1'b0}};
      rd_ptr_r <= {PTRW{1'b0}};
      count_r  <= {(PTRW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(PTRW-1){1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PTRW-1){1'b0}}, 1'b1};
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + {{PTRW{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{PTRW{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ofmap_writer.sv
// Writes the output stream into result memory at channel-major addresses
// through a two-stage pipeline and a small elastic buffer; reports completion.
module ofmap_writer
  import ofmap_writer_pkg::*;
#(
  parameter int IO_DATA_WIDTH      = 16,
  parameter int EXT_MEM_WIDTH      = 32,
  parameter int EXT_MEM_HEIGHT     = 1 << 20,
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int FIFO_DEPTH         = 8
) (
  input  logic                                     clk,
  input  logic                                     arst_n_in,
  input  logic                                     start,
  input  logic [count_width(coord_width(FEATURE_MAP_WIDTH), coord_width(FEATURE_MAP_HEIGHT),
                            coord_width(OUTPUT_NB_CHANNELS))-1:0] expected_count,
  input  logic [addr_width(EXT_MEM_HEIGHT)-1:0]    base_addr,
  input  logic [IO_DATA_WIDTH-1:0]                 in_data,
  input  logic                                     in_valid,
  input  logic [coord_width(FEATURE_MAP_WIDTH)-1:0]  in_x,
  input  logic [coord_width(FEATURE_MAP_HEIGHT)-1:0] in_y,
  input  logic [coord_width(OUTPUT_NB_CHANNELS)-1:0] in_ch,
  output logic                                     mem_write_en,
  input  logic                                     mem_grant,
  output logic [addr_width(EXT_MEM_HEIGHT)-1:0]    mem_write_addr,
  output logic [EXT_MEM_WIDTH-1:0]                 mem_din,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     overflow
);

  localparam int XW   = coord_width(FEATURE_MAP_WIDTH);
  localparam int YW   = coord_width(FEATURE_MAP_HEIGHT);
  localparam int CW   = coord_width(OUTPUT_NB_CHANNELS);
  localparam int NW   = count_width(XW, YW, CW);
  localparam int AW   = addr_width(EXT_MEM_HEIGHT);
  localparam int PW   = XW + YW + CW + AW;
  localparam int FW   = AW + EXT_MEM_WIDTH;
  localparam int FCW  = $clog2(FIFO_DEPTH) + 1;

  state_e                   state_r;
  state_e                   state_next_s;
  logic [NW-1:0]            exp_count_r;
  logic [NW-1:0]            rcv_count_r;
  logic [NW-1:0]            rcv_next_s;
  logic [AW-1:0]            base_addr_r;
  logic                     overflow_r;
  logic                     busy_r;
  logic                     done_r;

  logic                     s1_valid_r;
  logic [IO_DATA_WIDTH-1:0] s1_data_r;
  logic [XW-1:0]            s1_x_r;
  logic [YW-1:0]            s1_y_r;
  logic [CW-1:0]            s1_ch_r;

  logic [PW-1:0]            lin_addr_s;
  logic [AW-1:0]            wr_addr_s;
  logic [EXT_MEM_WIDTH-1:0] wr_data_s;
  logic [FW-1:0]            head_s;
  logic                     fifo_full_s;
  logic                     fifo_empty_s;
  logic [FCW-1:0]           fifo_count_s;

  logic                     accept_s;
  logic                     start_ok_s;
  logic                     pop_s;
  logic                     drop_s;
  logic                     drain_last_s;

  assign accept_s   = (state_r == ST_RUN) && in_valid;
  assign start_ok_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign rcv_next_s = rcv_count_r + {{(NW-1){1'b0}}, accept_s};
  assign pop_s      = mem_grant && !fifo_empty_s;
  assign drop_s     = s1_valid_r && fifo_full_s && !pop_s;

  // Pipeline empties this cycle: nothing in stage 1 and the buffer is empty or losing its last entry
  assign drain_last_s = !s1_valid_r &&
                        (fifo_empty_s || (pop_s && (fifo_count_s == FCW'(1))));

  // Stage 2: constant-coefficient channel-major address, wrapped to memory depth
  assign lin_addr_s = (PW'(s1_ch_r) * PW'(FEATURE_MAP_HEIGHT) + PW'(s1_y_r))
                      * PW'(FEATURE_MAP_WIDTH) + PW'(s1_x_r) + PW'(base_addr_r);
  assign wr_addr_s  = lin_addr_s[AW-1:0];
  assign wr_data_s  = {{(EXT_MEM_WIDTH-IO_DATA_WIDTH){s1_data_r[IO_DATA_WIDTH-1]}}, s1_data_r};

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (arst_n_in),
    .push  (s1_valid_r),
    .pop   (pop_s),
    .din   ({wr_addr_s, wr_data_s}),
    .head  (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Memory side is driven straight from the buffer head, forced to zero when idle
  assign mem_write_en   = !fifo_empty_s;
  assign mem_write_addr = fifo_empty_s ? {AW{1'b0}} : head_s[FW-1:EXT_MEM_WIDTH];
  assign mem_din        = fifo_empty_s ? {EXT_MEM_WIDTH{1'b0}} : head_s[EXT_MEM_WIDTH-1:0];
  assign busy           = busy_r;
  assign done           = done_r;
  assign overflow       = overflow_r;

  // Frame sequencing
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) state_next_s = ST_RUN;
        else            state_next_s = ST_IDLE;
      end
      ST_RUN: begin
        if (rcv_next_s >= exp_count_r) state_next_s = ST_DRAIN;
        else                           state_next_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (drain_last_s) state_next_s = ST_DONE;
        else              state_next_s = ST_DRAIN;
      end
      ST_DONE: begin
        if (start_ok_s) state_next_s = ST_RUN;
        else            state_next_s = ST_DONE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, frame registers and status flags
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_r     <= ST_IDLE;
      exp_count_r <= {NW{1'b0}};
      rcv_count_r <= {NW{1'b0}};
      base_addr_r <= {AW{1'b0}};
      overflow_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == ST_RUN) || (state_next_s == ST_DRAIN);
      done_r  <= (state_next_s == ST_DONE);
      if (start_ok_s) begin
        exp_count_r <= expected_count;
        base_addr_r <= base_addr;
        rcv_count_r <= {NW{1'b0}};
        overflow_r  <= 1'b0;
      end else begin
        rcv_count_r <= rcv_next_s;
        if (drop_s) begin
          overflow_r <= 1'b1;
        end
      end
    end
  end

  // Stage 1 input capture
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= {IO_DATA_WIDTH{1'b0}};
      s1_x_r     <= {XW{1'b0}};
      s1_y_r     <= {YW{1'b0}};
      s1_ch_r    <= {CW{1'b0}};
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_data_r <= in_data;
        s1_x_r    <= in_x;
        s1_y_r    <= in_y;
        s1_ch_r   <= in_ch;
      end
    end
  end

endmodule

// File: tb/tb_ofmap_writer.sv
// Directed-plus-random bench for ofmap_writer on a 4x4x2 map with a 4096-word memory.
// Expected writes come from the address formula applied to each word sent.
module tb_ofmap_writer;

  localparam int FWID  = 4;
  localparam int FHGT  = 4;
  localparam int NCH   = 2;
  localparam int MEMH  = 4096;
  localparam int DEPTH = 8;
  localparam int XW    = 2;
  localparam int YW    = 2;
  localparam int CW    = 1;
  localparam int NW    = 6;
  localparam int AW    = 12;

  logic          clk = 1'b0;
  logic          arst_n_in = 1'b0;
  logic          start = 1'b0;
  logic [NW-1:0] expected_count = '0;
  logic [AW-1:0] base_addr = '0;
  logic [15:0]   in_data = '0;
  logic          in_valid = 1'b0;
  logic [XW-1:0] in_x = '0;
  logic [YW-1:0] in_y = '0;
  logic [CW-1:0] in_ch = '0;
  logic          mem_write_en;
  logic          mem_grant = 1'b0;
  logic [AW-1:0] mem_write_addr;
  logic [31:0]   mem_din;
  logic          busy;
  logic          done;
  logic          overflow;

  int tests_run = 0;
  int tests_failed = 0;
  int cur_base = 0;

  logic [AW-1:0] got_addr_q[$];
  logic [31:0]   got_data_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [31:0]   exp_data_q[$];

  ofmap_writer #(
    .IO_DATA_WIDTH      (16),
    .EXT_MEM_WIDTH      (32),
    .EXT_MEM_HEIGHT     (MEMH),
    .FEATURE_MAP_WIDTH  (FWID),
    .FEATURE_MAP_HEIGHT (FHGT),
    .OUTPUT_NB_CHANNELS (NCH),
    .FIFO_DEPTH         (DEPTH)
  ) dut (
    .clk            (clk),
    .arst_n_in      (arst_n_in),
    .start          (start),
    .expected_count (expected_count),
    .base_addr      (base_addr),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_x           (in_x),
    .in_y           (in_y),
    .in_ch          (in_ch),
    .mem_write_en   (mem_write_en),
    .mem_grant      (mem_grant),
    .mem_write_addr (mem_write_addr),
    .mem_din        (mem_din),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  // Memory-side monitor: a write happens on every cycle with request and grant
  always @(negedge clk) begin
    if (arst_n_in && mem_write_en && mem_grant) begin
      got_addr_q.push_back(mem_write_addr);
      got_data_q.push_back(mem_din);
    end
  end

  function automatic logic [AW-1:0] ref_addr(input int base, input int x, input int y, input int ch);
    int lin;
    lin = base + (ch * FHGT + y) * FWID + x;
    return AW'(lin % MEMH);
  endfunction

  function automatic logic [31:0] ref_din(input logic [15:0] d);
    int v;
    v = int'($signed(d));
    return 32'(v);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int cnt, input int base);
    start = 1'b1;
    expected_count = NW'(cnt);
    base_addr = AW'(base);
    cur_base = base;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input int x, input int y, input int ch, input logic [15:0] d);
    in_x = XW'(x);
    in_y = YW'(y);
    in_ch = CW'(ch);
    in_data = d;
    in_valid = 1'b1;
    exp_addr_q.push_back(ref_addr(cur_base, x, y, ch));
    exp_data_q.push_back(ref_din(d));
    tick();
  endtask

  task automatic send_rand();
    send_word($urandom_range(0, FWID-1), $urandom_range(0, FHGT-1),
              $urandom_range(0, NCH-1), 16'($urandom));
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done"}, 64'(done), 64'(1));
  endtask

  task automatic check_writes(input string tag);
    int n;
    check({tag, "_nwrites"}, 64'(got_addr_q.size()), 64'(exp_addr_q.size()));
    n = (got_addr_q.size() < exp_addr_q.size()) ? got_addr_q.size() : exp_addr_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr%0d", tag, i), 64'(got_addr_q[i]), 64'(exp_addr_q[i]));
      check($sformatf("%s_din%0d", tag, i), 64'(got_data_q[i]), 64'(exp_data_q[i]));
    end
    got_addr_q.delete();
    got_data_q.delete();
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  initial begin
    int sent;
    int guard;
    int cnt;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_en", 64'(mem_write_en), 64'(0));
    check("rst_addr", 64'(mem_write_addr), 64'(0));
    check("rst_din", 64'(mem_din), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_ovf", 64'(overflow), 64'(0));
    arst_n_in = 1'b1;
    tick();

    // Words without a start are ignored
    in_valid = 1'b1;
    in_data = 16'h1234;
    repeat (5) tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("idle_en", 64'(mem_write_en), 64'(0));
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_writes", 64'(got_addr_q.size()), 64'(0));

    // Directed word: address 0x119, data -3, visible two cycles after acceptance
    mem_grant = 1'b0;
    do_start(8, 12'h100);
    check("run_busy", 64'(busy), 64'(1));
    send_word(1, 2, 1, 16'hFFFD);
    in_valid = 1'b0;
    check("lat1_en", 64'(mem_write_en), 64'(0));
    tick();
    check("lat2_en", 64'(mem_write_en), 64'(1));
    check("lat2_addr", 64'(mem_write_addr), 64'h119);
    check("lat2_din", 64'(mem_din), 64'hFFFF_FFFD);
    tick();
    check("hold_addr", 64'(mem_write_addr), 64'h119);
    mem_grant = 1'b1;
    repeat (7) send_rand();
    in_valid = 1'b0;
    wait_done("f8", 50);
    check("f8_busy", 64'(busy), 64'(0));
    check_writes("f8");

    // Words in DONE are ignored
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("donein_writes", 64'(got_addr_q.size()), 64'(0));
    check("donein_done", 64'(done), 64'(1));

    // Earliest completion, base near the top so addresses wrap
    do_start(6, 12'hFF0);
    repeat (5) send_rand();
    send_word(3, 3, 1, 16'h8000);
    in_valid = 1'b0;
    tick();
    check("early_done_t2", 64'(done), 64'(0));
    tick();
    check("early_done_t3", 64'(done), 64'(1));
    check("early_busy_t3", 64'(busy), 64'(0));
    check_writes("early");

    // Grant held low: only the first DEPTH words fit, the rest are dropped
    mem_grant = 1'b0;
    do_start(10, $urandom_range(0, MEMH-1));
    repeat (10) send_rand();
    in_valid = 1'b0;
    repeat (3) tick();
    check("ovf_flag", 64'(overflow), 64'(1));
    check("ovf_busy", 64'(busy), 64'(1));
    check("ovf_done", 64'(done), 64'(0));
    while (exp_addr_q.size() > DEPTH) begin
      void'(exp_addr_q.pop_back());
      void'(exp_data_q.pop_back());
    end
    mem_grant = 1'b1;
    wait_done("ovf", 50);
    check("ovf_sticky", 64'(overflow), 64'(1));
    check_writes("ovf");

    // Push into a full buffer on the same cycle as a pop: nothing lost
    mem_grant = 1'b0;
    do_start(9, $urandom_range(0, MEMH-1));
    check("ovf_cleared", 64'(overflow), 64'(0));
    repeat (9) send_rand();
    in_valid = 1'b0;
    mem_grant = 1'b1;
    wait_done("pp", 50);
    check("pp_ovf", 64'(overflow), 64'(0));
    check_writes("pp");

    // Empty frame: RUN and DRAIN one cycle each
    do_start(0, 12'h010);
    check("zero_busy1", 64'(busy), 64'(1));
    tick();
    check("zero_busy2", 64'(busy), 64'(1));
    tick();
    check("zero_busy3", 64'(busy), 64'(0));
    check("zero_done", 64'(done), 64'(1));
    check_writes("zero");

    // Random frames with random grant; at most DEPTH words outstanding so nothing drops
    for (int f = 0; f < 3; f++) begin
      cnt = $urandom_range(1, 20);
      do_start(cnt, $urandom_range(0, MEMH-1));
      sent = 0;
      guard = 0;
      while (sent < cnt && guard < 2000) begin
        mem_grant = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) != 0 && (sent - got_addr_q.size()) < DEPTH) begin
          send_rand();
          sent++;
        end else begin
          in_valid = 1'b0;
          tick();
        end
        guard++;
      end
      in_valid = 1'b0;
      mem_grant = 1'b1;
      wait_done($sformatf("rnd%0d", f), 100);
      check($sformatf("rnd%0d_ovf", f), 64'(overflow), 64'(0));
      check_writes($sformatf("rnd%0d", f));
    end

    // Reset while draining buffered words
    mem_grant = 1'b0;
    do_start(5, $urandom_range(0, MEMH-1));
    repeat (5) send_rand();
    in_valid = 1'b0;
    repeat (3) tick();
    check("mid_busy", 64'(busy), 64'(1));
    check("mid_en", 64'(mem_write_en), 64'(1));
    exp_addr_q.delete();
    exp_data_q.delete();
    arst_n_in = 1'b0;
    #1;
    check("mid_rst_en", 64'(mem_write_en), 64'(0));
    check("mid_rst_addr", 64'(mem_write_addr), 64'(0));
    check("mid_rst_din", 64'(mem_din), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    mem_grant = 1'b1;
    repeat (2) tick();
    arst_n_in = 1'b1;
    repeat (4) tick();
    check("post_rst_busy", 64'(busy), 64'(0));
    check("post_rst_done", 64'(done), 64'(0));
    check_writes("post_rst");

    do_start(4, $urandom_range(0, MEMH-1));
    repeat (4) send_rand();
    in_valid = 1'b0;
    wait_done("clean", 50);
    check("clean_ovf", 64'(overflow), 64'(0));
    check_writes("clean");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
